// File: rtl/comparator_cal_pkg.sv
// Shared types and trim-mapping helpers for the comparator offset calibration block.
// The trim is a 6-bit unsigned search code u with t = u - 32, split into p and n buses.
package comparator_cal_pkg;

    localparam int unsigned TRIM_BITS = 5;
    localparam int unsigned CODE_BITS = 6;

    typedef enum logic [2:0] {
        StIdle,
        StShort,
        StTrial,
        StSample,
        StDecide,
        StCommit
    } cal_state_e;

    typedef struct packed {
        logic [TRIM_BITS-1:0] p;
        logic [TRIM_BITS-1:0] n_rev;
    } trim_t;

    function automatic logic [TRIM_BITS-1:0] bitrev5(input logic [TRIM_BITS-1:0] x);
        logic [TRIM_BITS-1:0] r;
        for (int i = 0; i < TRIM_BITS; i++) begin
            r[i] = x[TRIM_BITS-1-i];
        end
        return r;
    endfunction

    // u = 0 (t = -32) has no representation; the search never drives it.
    function automatic trim_t u_to_trim(input logic [CODE_BITS-1:0] u);
        trim_t                r;
        logic [CODE_BITS-1:0] mag;
        if (u[CODE_BITS-1]) begin
            mag     = '0;
            r.p     = u[TRIM_BITS-1:0];
            r.n_rev = '0;
        end else begin
            mag     = CODE_BITS'(32) - u;
            r.p     = '0;
            r.n_rev = bitrev5(mag[TRIM_BITS-1:0]);
        end
        return r;
    endfunction

endpackage

// File: rtl/comparator_offset_cal_if.sv
// Control/result bundle between a host and the offset calibration controller.
interface comparator_offset_cal_if;
    import comparator_cal_pkg::*;

    logic                 start;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic [CODE_BITS-1:0] cal_code;
    logic                 sat;

    modport master (
        output start,
        output abort,
        input  busy,
        input  done,
        input  cal_code,
        input  sat
    );

    modport slave (
        input  start,
        input  abort,
        output busy,
        output done,
        output cal_code,
        output sat
    );

endinterface

// File: rtl/cal_sync2.sv
// Two-flop synchronizer for the asynchronous comparator decision.
module cal_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/comparator_offset_cal.sv
// Foreground offset calibration: shorts the comparator inputs and runs a majority-voted
// 6-step SAR search over the trim code, then holds the committed trim until the next run.
module comparator_offset_cal
    import comparator_cal_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned N_VOTE        = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    comparator_offset_cal_if.slave  ctrl_io,
    input  logic                    comp_out_i,
    output logic                    cal_short_o,
    output logic [TRIM_BITS-1:0]    cfg_offset_p_o,
    output logic [TRIM_BITS-1:0]    cfg_offset_n_o
);

    localparam int unsigned CntMax = (SETTLE_CYCLES > N_VOTE) ? SETTLE_CYCLES : N_VOTE;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned VoteW  = $clog2(N_VOTE + 1);

    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] VoteLast   = CntW'(N_VOTE - 1);
    localparam logic [2:0]      KTop       = 3'd5;

    cal_state_e           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [VoteW-1:0]     ones_q, ones_d;
    logic [CODE_BITS-1:0] u_q, u_d;
    logic [2:0]           k_q, k_d;
    trim_t                trim_q, trim_d;
    trim_t                committed_q, committed_d;
    logic                 busy_q, busy_d;
    logic                 short_q, short_d;
    logic                 done_q, done_d;
    logic                 sat_q, sat_d;
    logic [CODE_BITS-1:0] code_q, code_d;

    logic                 comp_sync;
    logic                 majority;
    logic [CODE_BITS-1:0] trial_u;
    logic [CODE_BITS-1:0] u_keep;
    logic [CODE_BITS-1:0] next_trial_u;
    logic [CODE_BITS-1:0] u_final;
    logic [2:0]           k_next;

    cal_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (comp_out_i),
        .q_o (comp_sync)
    );

    // Majority 0 means the trial trim still leaves the comparator low, so keep the bit.
    always_comb begin
        trial_u      = u_q | (CODE_BITS'(1) << k_q);
        majority     = (32'(ones_q) * 32'd2) > N_VOTE;
        u_keep       = majority ? u_q : trial_u;
        k_next       = k_q - 3'd1;
        next_trial_u = u_keep | (CODE_BITS'(1) << k_next);
        u_final      = (&u_q) ? u_q : u_q + CODE_BITS'(1);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ones_d      = ones_q;
        u_d         = u_q;
        k_d         = k_q;
        trim_d      = trim_q;
        committed_d = committed_q;
        busy_d      = busy_q;
        short_d     = short_q;
        done_d      = 1'b0;
        sat_d       = sat_q;
        code_d      = code_q;

        if (ctrl_io.abort && (state_q != StIdle)) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            short_d = 1'b0;
            trim_d  = committed_q;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ctrl_io.start && !ctrl_io.abort) begin
                        state_d = StShort;
                        busy_d  = 1'b1;
                        short_d = 1'b1;
                        u_d     = '0;
                        k_d     = KTop;
                        cnt_d   = '0;
                    end
                end
                StShort: begin
                    if (cnt_q == SettleLast) begin
                        cnt_d   = '0;
                        trim_d  = u_to_trim(trial_u);
                        state_d = StTrial;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StTrial: begin
                    if (cnt_q == SettleLast) begin
                        cnt_d   = '0;
                        ones_d  = '0;
                        state_d = StSample;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StSample: begin
                    ones_d = ones_q + VoteW'(comp_sync);
                    if (cnt_q == VoteLast) begin
                        cnt_d   = '0;
                        state_d = StDecide;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StDecide: begin
                    u_d = u_keep;
                    if (k_q != 3'd0) begin
                        k_d     = k_next;
                        trim_d  = u_to_trim(next_trial_u);
                        state_d = StTrial;
                    end else begin
                        state_d = StCommit;
                    end
                end
                StCommit: begin
                    trim_d      = u_to_trim(u_final);
                    committed_d = u_to_trim(u_final);
                    code_d      = u_final - CODE_BITS'(32);
                    sat_d       = (u_final == CODE_BITS'(63)) || (u_final == CODE_BITS'(1));
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    short_d     = 1'b0;
                    state_d     = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ones_q      <= '0;
            u_q         <= '0;
            k_q         <= '0;
            trim_q      <= '0;
            committed_q <= '0;
            busy_q      <= 1'b0;
            short_q     <= 1'b0;
            done_q      <= 1'b0;
            sat_q       <= 1'b0;
            code_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ones_q      <= ones_d;
            u_q         <= u_d;
            k_q         <= k_d;
            trim_q      <= trim_d;
            committed_q <= committed_d;
            busy_q      <= busy_d;
            short_q     <= short_d;
            done_q      <= done_d;
            sat_q       <= sat_d;
            code_q      <= code_d;
        end
    end

    assign ctrl_io.busy     = busy_q;
    assign ctrl_io.done     = done_q;
    assign ctrl_io.cal_code = code_q;
    assign ctrl_io.sat      = sat_q;
    assign cal_short_o      = short_q;
    assign cfg_offset_p_o   = trim_q.p;
    assign cfg_offset_n_o   = trim_q.n_rev;

endmodule

// File: tb/tb_comparator_offset_cal.sv
// Scoreboard bench: two controllers (N_VOTE = 3 and 1) each closed around a behavioural
// comparator with a programmable input offset; expected results come from clamping -vos.
module tb_comparator_offset_cal;

    localparam longint Lat0 = 1 + 16 + 6 * (16 + 3 + 1);
    localparam longint Lat1 = 1 + 16 + 6 * (16 + 1 + 1);

    typedef struct {
        int     code;
        int     p;
        int     n;
        int     sat;
        longint due;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     vos0 = 0;
    int     vos1 = 0;
    logic   noise_en = 1'b0;
    logic   noise = 1'b0;
    int     gap = 0;
    exp_t   q0[$];
    exp_t   q1[$];

    logic       short0, short1, comp0, comp1;
    logic [4:0] p0, n0, p1, n1;

    comparator_offset_cal_if ifc0 ();
    comparator_offset_cal_if ifc1 ();

    comparator_offset_cal #(.SETTLE_CYCLES(16), .N_VOTE(3)) u_dut0 (
        .clk            (clk),
        .rst            (rst),
        .ctrl_io        (ifc0),
        .comp_out_i     (comp0),
        .cal_short_o    (short0),
        .cfg_offset_p_o (p0),
        .cfg_offset_n_o (n0)
    );

    comparator_offset_cal #(.SETTLE_CYCLES(16), .N_VOTE(1)) u_dut1 (
        .clk            (clk),
        .rst            (rst),
        .ctrl_io        (ifc1),
        .comp_out_i     (comp1),
        .cal_short_o    (short1),
        .cfg_offset_p_o (p1),
        .cfg_offset_n_o (n1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rev5(input int x);
        int r = 0;
        for (int i = 0; i < 5; i++) r |= ((x >> i) & 1) << (4 - i);
        return r;
    endfunction

    // Ideal SAR lands on the smallest in-range trim that makes vos + t >= 0.
    function automatic exp_t model(input int v, input longint due);
        exp_t m;
        int   t = -v;
        if (t > 31) t = 31;
        if (t < -31) t = -31;
        m.code = t;
        m.p    = (t > 0) ? t : 0;
        m.n    = rev5((t < 0) ? -t : 0);
        m.sat  = ((t == 31) || (t == -31)) ? 1 : 0;
        m.due  = due;
        return m;
    endfunction

    assign comp0 = ((vos0 + int'(p0) - rev5(int'(n0))) >= 0) ^ noise;
    assign comp1 = (vos1 + int'(p1) - rev5(int'(n1))) >= 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One-cycle glitches at least 4 cycles apart: at most one flipped sample per 3-vote.
    initial begin
        forever begin
            @(negedge clk);
            if (noise_en && gap == 0) begin
                noise = 1'b1;
                gap   = $urandom_range(6, 3);
            end else begin
                noise = 1'b0;
                if (gap > 0) gap--;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("dut0_short_eq_busy", short0, ifc0.busy);
            if (ifc0.done) begin
                check("dut0_done_expected", longint'(q0.size() > 0), 1);
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    check("dut0_cal_code", longint'($signed(ifc0.cal_code)), e.code);
                    check("dut0_p_bus", p0, e.p);
                    check("dut0_n_bus", n0, e.n);
                    check("dut0_sat", ifc0.sat, e.sat);
                    check("dut0_latency", cyc, e.due);
                    check("dut0_busy_at_done", ifc0.busy, 0);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("dut1_short_eq_busy", short1, ifc1.busy);
            if (ifc1.done) begin
                check("dut1_done_expected", longint'(q1.size() > 0), 1);
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    check("dut1_cal_code", longint'($signed(ifc1.cal_code)), e.code);
                    check("dut1_p_bus", p1, e.p);
                    check("dut1_n_bus", n1, e.n);
                    check("dut1_sat", ifc1.sat, e.sat);
                    check("dut1_latency", cyc, e.due);
                end
            end
        end
    end

    task automatic pulse_start0();
        ifc0.start = 1'b1;
        @(negedge clk);
        ifc0.start = 1'b0;
    endtask

    task automatic cal0(input int v);
        vos0 = v;
        q0.push_back(model(v, cyc + 1 + Lat0));
        pulse_start0();
    endtask

    task automatic cal1(input int v);
        vos1 = v;
        q1.push_back(model(v, cyc + 1 + Lat1));
        ifc1.start = 1'b1;
        @(negedge clk);
        ifc1.start = 1'b0;
    endtask

    task automatic wait0();
        int n = 0;
        while (q0.size() != 0 && n < Lat0 + 20) begin
            @(negedge clk);
            n++;
        end
        check("dut0_timeout_pending", q0.size(), 0);
        q0.delete();
        @(negedge clk);
    endtask

    task automatic wait1();
        int n = 0;
        while (q1.size() != 0 && n < Lat1 + 20) begin
            @(negedge clk);
            n++;
        end
        check("dut1_timeout_pending", q1.size(), 0);
        q1.delete();
        @(negedge clk);
    endtask

    task automatic check_zero0(input string tag);
        check({tag, "_busy"}, ifc0.busy, 0);
        check({tag, "_done"}, ifc0.done, 0);
        check({tag, "_short"}, short0, 0);
        check({tag, "_code"}, ifc0.cal_code, 0);
        check({tag, "_sat"}, ifc0.sat, 0);
        check({tag, "_p"}, p0, 0);
        check({tag, "_n"}, n0, 0);
    endtask

    initial begin
        int directed[5] = '{-7, 5, 0, -40, 40};
        ifc0.start = 1'b0;
        ifc0.abort = 1'b0;
        ifc1.start = 1'b0;
        ifc1.abort = 1'b0;
        #1;
        check_zero0("reset0");
        check("reset1_busy", ifc1.busy, 0);
        check("reset1_code", ifc1.cal_code, 0);
        check("reset1_p", p1, 0);
        check("reset1_n", n1, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (directed[i]) begin
            cal0(directed[i]);
            wait0();
        end
        repeat (6) begin
            cal0(int'($urandom_range(90)) - 45);
            wait0();
        end

        noise_en = 1'b1;
        cal0(-7);
        wait0();
        repeat (3) begin
            cal0(int'($urandom_range(70)) - 35);
            wait0();
        end
        noise_en = 1'b0;

        // A second start while busy must not restart the run (latency is checked on done).
        cal0(int'($urandom_range(60)) - 30);
        repeat (30) @(negedge clk);
        pulse_start0();
        wait0();

        // Start and abort together while idle: abort wins.
        ifc0.start = 1'b1;
        ifc0.abort = 1'b1;
        @(negedge clk);
        ifc0.start = 1'b0;
        ifc0.abort = 1'b0;
        check("idle_abort_wins_busy", ifc0.busy, 0);

        // Abort mid-run reverts to the previously committed +7.
        cal0(-7);
        wait0();
        vos0 = 5;
        pulse_start0();
        repeat (19) @(negedge clk);
        pulse_start0();
        repeat (29) @(negedge clk);
        check("abort_busy_before", ifc0.busy, 1);
        ifc0.abort = 1'b1;
        @(negedge clk);
        ifc0.abort = 1'b0;
        check("abort_busy", ifc0.busy, 0);
        check("abort_short", short0, 0);
        check("abort_code", longint'($signed(ifc0.cal_code)), 7);
        check("abort_p", p0, 7);
        check("abort_n", n0, 0);
        check("abort_sat", ifc0.sat, 0);
        repeat (160) @(negedge clk);
        check("abort_no_restart_busy", ifc0.busy, 0);

        // Asynchronous reset in the middle of a run.
        cal0(int'($urandom_range(60)) - 30);
        repeat (59) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero0("midreset");
        q0.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cal0(int'($urandom_range(90)) - 45);
        wait0();

        cal1(-7);
        wait1();
        repeat (3) begin
            cal1(int'($urandom_range(90)) - 45);
            wait1();
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
